// File: rtl/count_nox_loader_if.sv
// count_nox_loader_if
// Signal bundle between the loader and its environment:
//   host side    : start, x_in, result, result_valid, result_ack, busy
//   byte stream  : in_valid, in_data, in_ready
//   counter side : go, x, address, dataIn, done, freq
// The master modport is the environment (host + counter). The slave
// modport is the loader itself.
interface count_nox_loader_if;
    logic       start;
    logic [7:0] x_in;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       go;
    logic [7:0] x;
    logic [7:0] address;
    logic [7:0] dataIn;
    logic       done;
    logic [7:0] freq;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ack;
    logic       busy;

    modport master (
        output start, x_in, in_valid, in_data, address, done, freq, result_ack,
        input  in_ready, go, x, dataIn, result, result_valid, busy
    );

    modport slave (
        input  start, x_in, in_valid, in_data, address, done, freq, result_ack,
        output in_ready, go, x, dataIn, result, result_valid, busy
    );
endinterface

// File: rtl/count_nox_loader.sv
// count_nox_loader
// Front end for the CountNox counter. Latches the search value, collects
// SIZE array bytes from a valid/ready stream, serves them back through a
// combinational read port, launches the counter with a one-cycle go and
// holds the returned frequency until the host acknowledges it.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : count_nox_loader_if.slave (host, stream and counter signals)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting array bytes
// GO     | single-cycle launch of the counter
// RUN    | waiting for a fresh done from the counter
// HOLD   | result valid, waiting for result_ack
module count_nox_loader #(
    parameter int SIZE = 8
) (
    input  logic               clk,
    input  logic               reset,
    count_nox_loader_if.slave  bus
);

    localparam int         IW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [7:0] LAST   = 8'(SIZE - 1);
    localparam logic [8:0] SIZE_W = 9'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_RUN,
        S_HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] x_q;
    logic [7:0] result_q;
    logic [7:0] wr_ptr;
    logic       seen_low;
    logic [7:0] mem [0:SIZE-1];

    logic       in_ready;
    logic       go;
    logic       result_valid;
    logic       busy;
    logic       start_fire;
    logic       load_fire;
    logic       capture;
    logic [7:0] data_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        go           = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        start_fire   = 1'b0;
        load_fire    = 1'b0;
        capture      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    start_fire = 1'b1;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_fire = 1'b1;
                    if (wr_ptr == LAST) begin
                        state_nxt = S_GO;
                    end
                end
            end
            S_GO: begin
                go        = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Only a done that rises after launch counts; a level left
                // over from the previous run must be seen low first.
                if (bus.done && seen_low) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                result_valid = 1'b1;
                if (bus.result_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q      <= 8'h00;
            wr_ptr   <= 8'h00;
            seen_low <= 1'b0;
            result_q <= 8'h00;
        end else begin
            if (start_fire) begin
                x_q    <= bus.x_in;
                wr_ptr <= 8'h00;
            end
            if (load_fire) begin
                wr_ptr <= wr_ptr + 8'h01;
            end
            if (state == S_GO) begin
                seen_low <= 1'b0;
            end
            if (state == S_RUN && !bus.done) begin
                seen_low <= 1'b1;
            end
            if (capture) begin
                result_q <= bus.freq;
            end
        end
    end

    // Array storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reset && load_fire) begin
            mem[wr_ptr[IW-1:0]] <= bus.in_data;
        end
    end

    always_comb begin
        data_rd = 8'h00;
        if ({1'b0, bus.address} < SIZE_W) begin
            data_rd = mem[bus.address[IW-1:0]];
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.go           = go;
    assign bus.x            = x_q;
    assign bus.dataIn       = data_rd;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid;
    assign bus.busy         = busy;

endmodule

// File: doc/count_nox_loader.md
# count_nox_loader

Front-end stage for `CountNox`. It latches the search value `x` and accepts `SIZE` array bytes over a valid/ready stream into an internal register array. It serves that array to the counter through the counter's `address`/`dataIn` read port, launches the counter with a one-cycle `go`, and holds the returned `freq` until the host acknowledges it.

## Interface
Parameters:
- `SIZE`, default 8: number of array entries; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  host request; sampled only in IDLE.
- `x_in`  in  8  search value; latched on an accepted `start`.
- `in_valid`  in  1  array byte valid.
- `in_data`  in  8  array byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `go`  out  1  one-cycle launch pulse to the counter.
- `x`  out  8  latched search value, driven to the counter.
- `address`  in  8  counter read address.
- `dataIn`  out  8  array byte at `address`, driven to the counter.
- `done`  in  1  counter completion flag.
- `freq`  in  8  counter result.
- `result`  out  8  captured `freq`.
- `result_valid`  out  1  `result` is valid.
- `result_ack`  in  1  host consumes `result`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Storage: `mem[0..SIZE-1]`, 8 bits per entry. Contents are not cleared by reset.
- Write pointer: `wr_ptr`, 8 bits.
- Read port is combinational:
  - `dataIn = mem[address]` when `address < SIZE`.
  - `dataIn = 8'h00` when `address >= SIZE`.
- State machine:
  - IDLE: `in_ready=0`. On `start`: `x <= x_in`, `wr_ptr <= 0`, go to LOAD.
  - LOAD: `in_ready=1`. On `in_valid`: `mem[wr_ptr] <= in_data` and `wr_ptr <= wr_ptr+1`. When the accepted byte has `wr_ptr == SIZE-1`, go to GO. Gaps in `in_valid` are allowed and simply stall.
  - GO: `go=1` for exactly this cycle; `seen_low <= 0`; go to RUN.
  - RUN: if `done==0`, set `seen_low <= 1`. If `done==1` and `seen_low==1`, set `result <= freq`, then go to HOLD. A `done` that stays high from a previous run is never captured.
  - HOLD: `result_valid=1`. On `result_ack`, go to IDLE. `result` keeps its value after HOLD until the next capture.
- `start` outside IDLE is ignored; `x` and `mem` are unchanged.
- `in_valid` outside LOAD is ignored; no write occurs.
- `result_ack` outside HOLD is ignored.
- `x` changes only on an accepted `start`. It is stable throughout LOAD, GO, RUN and HOLD.
- The loader has no timeout; a counter that never completes leaves it in RUN until reset.

## Timing
- Reset, with `reset==0` at a clock edge:
  - State goes to IDLE.
  - `in_ready`, `go`, `result_valid` and `busy` go to 0.
  - `x`, `result`, `wr_ptr` and `seen_low` go to 0.
  - Reset takes effect at that edge regardless of state; a mid-LOAD or mid-RUN operation is abandoned and no `go` follows.
- `start` accepted at edge t: `in_ready=1` and `busy=1` from cycle t+1.
- Byte handshake: a byte transfers on each edge where `in_valid && in_ready`. Throughput is one byte per cycle.
- Last byte accepted at edge k: `in_ready=0` from cycle k+1, and `go=1` during cycle k+1 only.
- Minimum load-to-go latency is SIZE+1 cycles after `start`.
- Capture: if the capture condition holds at edge m, then `result_valid=1` from cycle m+1 and `result` equals `freq` sampled at edge m.
- Acknowledge: `result_ack` at edge n gives `result_valid=0` and `busy=0` from cycle n+1. A new `start` is accepted at edge n+1 at the earliest.
- With `SIZE==1`, one accepted byte moves LOAD directly to GO.

## Test plan
- Basic run: SIZE=8, `x_in`=5, bytes {5,1,5,2,3,5,4,5} streamed back-to-back, real `CountNox` attached.
  - Exactly one `go` pulse, in the cycle after the 8th byte is accepted.
  - `result`=4 with `result_valid` high until `result_ack`.
- Bursty input: same data with `in_valid` toggling 1,0,0,1,…
  - Identical `mem` contents and `result`=4.
  - `in_ready` stays high throughout LOAD.
- Ignored inputs: `start` with `x_in`=9 pulsed during LOAD and again during RUN.
  - `x` stays 5, `wr_ptr` is unaffected, and exactly one run occurs.
- Stale done: stub counter holds `done`=1 through GO and RUN for 3 cycles, then `done`=0 for 2 cycles, then `done`=1 with `freq`=8'h2A.
  - No capture during the initial high period.
  - `result`=8'h2A, with `result_valid` rising in the cycle after `done` rises again.
- Reset mid-LOAD: assert `reset`=0 for one cycle after 4 bytes are accepted.
  - Next cycle: `busy`=0, `in_ready`=0, `x`=0.
  - `go` never pulses.
  - A following full load runs normally.
- Read port: after loading {10..17}:
  - `address`=3 gives `dataIn`=13.
  - `address`=7 gives `dataIn`=17.
  - `address`=8 and `address`=255 give `dataIn`=0.
